// File: rtl/nn_pkg.sv
// ============================================================================
// Module  : nn_pkg
// Brief   : Shared Q8.8 constants and FSM state encoding for the neural datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package nn_pkg;
    localparam int              DATA_W = 16;
    localparam logic [DATA_W-1:0] ONE  = 16'h0100;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_PRESENT = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;
endpackage

`default_nettype wire

// File: rtl/nn_rd_delay.sv
// ============================================================================
// Module  : nn_rd_delay
// Brief   : LAT-deep shift of a memory read strobe; output marks read data valid.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nn_rd_delay #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_strobe,
    output logic o_rd_valid
);

    logic [LAT-1:0] r_sh;

    generate
        if (LAT == 1) begin : g_single
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_sh <= '0;
                else       r_sh <= i_strobe;
            end
        end else begin : g_multi
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_sh <= '0;
                else       r_sh <= {r_sh[LAT-2:0], i_strobe};
            end
        end
    endgenerate

    assign o_rd_valid = r_sh[LAT-1];

endmodule

`default_nettype wire

// File: rtl/hidden_act_reader.sv
// ============================================================================
// Module  : hidden_act_reader
// Brief   : Replays stored hidden activations with layer-1 weights as a beat
//           stream to the MAC. Define ZERO_SKIP_EN to drop zero activations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

import nn_pkg::*;

module hidden_act_reader #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int WADDR_W = 10,
    parameter int N_HID   = 100,
    parameter int N_OUT   = 2,
    parameter int RD_LAT  = 1,
    parameter int OW      = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               mem_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               w_en,
    output logic [WADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0]  w_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_act,
    output logic [DATA_W-1:0]  out_wt,
    output logic               out_bias,
    output logic               out_last,
    output logic [OW-1:0]      out_idx
);

    localparam int IW = $clog2(N_HID + 1);

    logic [2:0]         r_state;
    logic [IW-1:0]      r_i;
    logic [OW-1:0]      r_o;
    logic [WADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0]  r_act;
    logic [DATA_W-1:0]  r_wt;
    logic               r_bias;

    logic w_bias_req;
    logic w_last_o;
    logic w_rd_valid;

    assign w_bias_req = (r_i == IW'(N_HID));
    assign w_last_o   = (r_o == OW'(N_OUT - 1));

    nn_rd_delay #(.LAT(RD_LAT)) u_rd_delay (
        .clk        (clk),
        .reset      (reset),
        .i_strobe   (r_state == ST_REQ),
        .o_rd_valid (w_rd_valid)
    );

    // Weight addresses are visited strictly in order, so a running counter
    // replaces the o*(N_HID+1)+i product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_i     <= '0;
            r_o     <= '0;
            r_waddr <= '0;
            r_act   <= '0;
            r_wt    <= '0;
            r_bias  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) r_state <= ST_REQ;
                end
                ST_REQ: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_rd_valid) begin
                        r_wt   <= w_rdata;
                        r_bias <= w_bias_req;
                        r_act  <= w_bias_req ? DATA_W'(ONE) : mem_rdata;
`ifdef ZERO_SKIP_EN
                        if (!w_bias_req && mem_rdata == '0) begin
                            r_i     <= r_i + 1'b1;
                            r_waddr <= r_waddr + 1'b1;
                            r_state <= ST_REQ;
                        end else begin
                            r_state <= ST_PRESENT;
                        end
`else
                        r_state <= ST_PRESENT;
`endif
                    end
                end
                ST_PRESENT: begin
                    if (out_ready) begin
                        r_waddr <= r_waddr + 1'b1;
                        if (w_bias_req) begin
                            r_i <= '0;
                            if (w_last_o) begin
                                r_o     <= '0;
                                r_waddr <= '0;
                                r_state <= ST_DONE;
                            end else begin
                                r_o     <= r_o + 1'b1;
                                r_state <= ST_REQ;
                            end
                        end else begin
                            r_i     <= r_i + 1'b1;
                            r_state <= ST_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign w_en      = (r_state == ST_REQ);
    assign mem_en    = (r_state == ST_REQ) && !w_bias_req;
    assign mem_addr  = ADDR_W'(r_i);
    assign w_addr    = r_waddr;
    assign out_valid = (r_state == ST_PRESENT);
    assign out_act   = r_act;
    assign out_wt    = r_wt;
    assign out_bias  = out_valid && r_bias;
    assign out_last  = out_bias;
    assign out_idx   = r_o;

endmodule

`default_nettype wire
